// File: rtl/traffic_phase_scheduler_if.sv
// Handshake bundle between the tick/request sources and the phase scheduler.
// TRAFFIC_PREEMPT_EN adds the preempt level to the bundle.
interface traffic_phase_scheduler_if #(
  parameter int CW = 8
);
  logic          tick;
  logic          ns_req;
  logic          ew_req;
`ifdef TRAFFIC_PREEMPT_EN
  logic          preempt;
`endif
  logic [5:0]    lights;
  logic          red_sel;
  logic          nsgreen_sel;
  logic          nstrans_sel;
  logic          ewgreen_sel;
  logic          ewtrans_sel;
  logic [CW-1:0] remaining;
  logic          phase_done;

  modport master (
`ifdef TRAFFIC_PREEMPT_EN
    output preempt,
`endif
    output tick, ns_req, ew_req,
    input  lights, red_sel, nsgreen_sel, nstrans_sel, ewgreen_sel, ewtrans_sel,
    input  remaining, phase_done
  );

  modport slave (
`ifdef TRAFFIC_PREEMPT_EN
    input  preempt,
`endif
    input  tick, ns_req, ew_req,
    output lights, red_sel, nsgreen_sel, nstrans_sel, ewgreen_sel, ewtrans_sel,
    output remaining, phase_done
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase sequencer with request-aware green timing, advanced by a tick strobe.
// Optional TRAFFIC_PREEMPT_EN: preempt level forces green to yellow and holds all-red.
//
// state    | meaning
// ---------+-----------------------------------------------
// NS_GREEN | north-south green, min/max timing vs pend_ew
// NS_YEL   | north-south transition
// RED_A    | all-red clearance before east-west
// EW_GREEN | east-west green, min/max timing vs pend_ns
// EW_YEL   | east-west transition
// RED_B    | all-red clearance before north-south (reset state)
module traffic_phase_scheduler #(
  parameter int CW        = 8,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 20,
  parameter int YEL_T     = 3,
  parameter int RED_T     = 2
) (
  input logic                  clk,
  input logic                  clr_n,
  traffic_phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    NS_GREEN = 3'd0,
    NS_YEL   = 3'd1,
    RED_A    = 3'd2,
    EW_GREEN = 3'd3,
    EW_YEL   = 3'd4,
    RED_B    = 3'd5
  } state_t;

  localparam logic [CW-1:0] G_DUR    = CW'(GREEN_MAX);
  localparam logic [CW-1:0] Y_DUR    = CW'(YEL_T);
  localparam logic [CW-1:0] R_DUR    = CW'(RED_T);
  localparam logic [CW-1:0] G_MIN_M1 = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] G_MAX_M1 = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] Y_M1     = CW'(YEL_T - 1);
  localparam logic [CW-1:0] R_M1     = CW'(RED_T - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pend_ns, pend_ns_nx;
  logic          pend_ew, pend_ew_nx;
  logic          hold, hold_nx;
  logic          change;
  logic          opp_pend;
  logic          pre;

  logic [5:0]    lights_q;
  logic [4:0]    sel_q;
  logic [CW-1:0] rem_q;
  logic          done_q;

`ifdef TRAFFIC_PREEMPT_EN
  assign pre = bus.preempt;
`else
  assign pre = 1'b0;
`endif

  function automatic state_t next_of(input state_t s);
    case (s)
      NS_GREEN: next_of = NS_YEL;
      NS_YEL:   next_of = RED_A;
      RED_A:    next_of = EW_GREEN;
      EW_GREEN: next_of = EW_YEL;
      EW_YEL:   next_of = RED_B;
      default:  next_of = NS_GREEN;
    endcase
  endfunction

  function automatic logic [CW-1:0] dur_of(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN: dur_of = G_DUR;
      NS_YEL, EW_YEL:     dur_of = Y_DUR;
      default:            dur_of = R_DUR;
    endcase
  endfunction

  function automatic logic [5:0] lights_of(input state_t s);
    case (s)
      NS_GREEN: lights_of = 6'b000001;
      NS_YEL:   lights_of = 6'b000010;
      RED_A:    lights_of = 6'b000100;
      EW_GREEN: lights_of = 6'b001000;
      EW_YEL:   lights_of = 6'b010000;
      default:  lights_of = 6'b100000;
    endcase
  endfunction

  // packed as {red, nsgreen, nstrans, ewgreen, ewtrans}
  function automatic logic [4:0] sel_of(input state_t s);
    case (s)
      NS_GREEN: sel_of = 5'b01000;
      NS_YEL:   sel_of = 5'b00100;
      EW_GREEN: sel_of = 5'b00010;
      EW_YEL:   sel_of = 5'b00001;
      default:  sel_of = 5'b10000;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hold_nx  = hold;
    change   = 1'b0;
    opp_pend = (state == NS_GREEN) ? pend_ew : pend_ns;

    case (state)
      NS_GREEN, EW_GREEN: begin
        if (pre) begin
          change = 1'b1;
        end else if (bus.tick) begin
          if ((cnt >= G_MIN_M1 && opp_pend) || cnt == G_MAX_M1) change = 1'b1;
          else cnt_nx = cnt + 1'b1;
        end
      end
      NS_YEL, EW_YEL: begin
        if (bus.tick) begin
          if (cnt == Y_M1) change = 1'b1;
          else cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        // a preempt seen during clearance lets the first tick after release exit
        if (pre) begin
          hold_nx = 1'b1;
          if (bus.tick && cnt != R_M1) cnt_nx = cnt + 1'b1;
        end else if (bus.tick) begin
          if (cnt == R_M1 || hold) change = 1'b1;
          else cnt_nx = cnt + 1'b1;
        end
      end
    endcase

    if (change) begin
      state_nx = next_of(state);
      cnt_nx   = '0;
      hold_nx  = 1'b0;
    end

    pend_ns_nx = (pend_ns | bus.ns_req) & ~(change && state_nx == NS_GREEN);
    pend_ew_nx = (pend_ew | bus.ew_req) & ~(change && state_nx == EW_GREEN);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= RED_B;
      cnt      <= '0;
      pend_ns  <= 1'b0;
      pend_ew  <= 1'b0;
      hold     <= 1'b0;
      lights_q <= 6'b100000;
      sel_q    <= 5'b10000;
      rem_q    <= R_DUR;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pend_ns  <= pend_ns_nx;
      pend_ew  <= pend_ew_nx;
      hold     <= hold_nx;
      lights_q <= lights_of(state_nx);
      sel_q    <= sel_of(state_nx);
      rem_q    <= dur_of(state_nx) - cnt_nx;
      done_q   <= change;
    end
  end

  assign bus.lights      = lights_q;
  assign bus.red_sel     = sel_q[4];
  assign bus.nsgreen_sel = sel_q[3];
  assign bus.nstrans_sel = sel_q[2];
  assign bus.ewgreen_sel = sel_q[1];
  assign bus.ewtrans_sel = sel_q[0];
  assign bus.remaining   = rem_q;
  assign bus.phase_done  = done_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed and randomized checks of traffic_phase_scheduler against a tick-level phase model.
module tb_traffic_phase_scheduler;

  localparam int GMIN = 5;
  localparam int GMAX = 20;
  localparam int YT   = 3;
  localparam int RT   = 2;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  traffic_phase_scheduler_if #(.CW(8)) bus();

  traffic_phase_scheduler dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // model: phase index in cyclic order (0=NS_GREEN .. 5=RED_B) and ticks spent in it
  int m_p, m_t;
  bit m_pns, m_pew, m_hold, m_done;
  bit pre_v = 1'b0;

  function automatic int dur(input int p);
    if (p == 0 || p == 3) return GMAX;
    if (p == 1 || p == 4) return YT;
    return RT;
  endfunction

  task automatic model_reset();
    m_p = 5; m_t = 0; m_pns = 0; m_pew = 0; m_hold = 0; m_done = 0;
  endtask

  task automatic model_step(input bit tk, input bit ns, input bit ew, input bit pre);
    bit leave, green, red, opp;
    leave = 0;
    green = (m_p == 0 || m_p == 3);
    red   = (m_p == 2 || m_p == 5);
    opp   = (m_p == 0) ? m_pew : m_pns;
    if (green && pre) leave = 1;
    else if (red && pre) begin
      m_hold = 1;
      if (tk && m_t < RT - 1) m_t++;
    end else if (tk) begin
      if (green)    leave = ((m_t + 1 >= GMIN) && opp) || (m_t + 1 == GMAX);
      else if (red) leave = (m_t + 1 == RT) || m_hold;
      else          leave = (m_t + 1 == YT);
      if (!leave) m_t++;
    end
    m_pns = m_pns | ns;
    m_pew = m_pew | ew;
    if (leave) begin
      m_p = (m_p + 1) % 6;
      m_t = 0;
      m_hold = 0;
      if (m_p == 0) m_pns = 0;
      if (m_p == 3) m_pew = 0;
    end
    m_done = leave;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [5:0] el;
    logic [4:0] es;
    el = 6'b000001 << m_p;
    case (m_p)
      0:       es = 5'b01000;
      1:       es = 5'b00100;
      3:       es = 5'b00010;
      4:       es = 5'b00001;
      default: es = 5'b10000;
    endcase
    chk("lights", 32'(bus.lights), 32'(el));
    chk("sels", 32'({bus.red_sel, bus.nsgreen_sel, bus.nstrans_sel,
                     bus.ewgreen_sel, bus.ewtrans_sel}), 32'(es));
    chk("remaining", 32'(bus.remaining), 32'(dur(m_p) - m_t));
    chk("phase_done", 32'(bus.phase_done), 32'(m_done));
  endtask

  // entered and left at a negedge
  task automatic cyc(input bit tk, input bit ns, input bit ew);
    bus.tick   = tk;
    bus.ns_req = ns;
    bus.ew_req = ew;
`ifdef TRAFFIC_PREEMPT_EN
    bus.preempt = pre_v;
`endif
    model_step(tk, ns, ew, pre_v);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic advance_to(input logic [5:0] tgt);
    int g;
    bit tk;
    g = 0; tk = 0;
    while (bus.lights !== tgt && g < 400) begin
      tk = !tk;
      cyc(tk, 1'b0, 1'b0);
      g++;
    end
    chk("advance_bound", 32'(g < 400), 32'd1);
  endtask

  int         exp_len [6] = '{2, 20, 3, 2, 20, 3};
  logic [5:0] exp_l   [6] = '{6'b100000, 6'b000001, 6'b000010,
                              6'b000100, 6'b001000, 6'b010000};

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph_ticks, guard, clk_i, g_ticks, done_hi;
    logic [5:0] ph_lights;
    bit tk;

    bus.tick = 0; bus.ns_req = 0; bus.ew_req = 0;
`ifdef TRAFFIC_PREEMPT_EN
    bus.preempt = 0;
`endif
    clr_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    clr_n = 1'b1;

    // 1: default timing, tick every 4 clk
    clk_i = 0;
    for (int k = 0; k < 6; k++) begin
      ph_ticks = 0; guard = 0;
      ph_lights = bus.lights;
      do begin
        tk = (clk_i % 4 == 3);
        clk_i++;
        cyc(tk, 1'b0, 1'b0);
        if (tk) ph_ticks++;
        guard++;
      end while (!bus.phase_done && guard < 200);
      chk("t1_bound", 32'(guard < 200), 32'd1);
      chk("t1_len", 32'(ph_ticks), 32'(exp_len[k]));
      chk("t1_order", 32'(ph_lights), 32'(exp_l[k]));
    end

    // 2: ew pulse at NS_GREEN cnt=1 -> 5-tick green
    advance_to(6'b000001);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    g_ticks = 1; guard = 0; tk = 0;
    do begin
      tk = !tk;
      cyc(tk, 1'b0, 1'b0);
      if (tk) g_ticks++;
      guard++;
    end while (!bus.phase_done && guard < 200);
    chk("t2_green_len", 32'(g_ticks), 32'd5);
    advance_to(6'b001000);
    chk("t2_pend_ew_clear", 32'(dut.pend_ew), 32'd0);

    // 3: ew request at cnt=9 -> 10-tick green, remaining 11 -> 3
    advance_to(6'b000001);
    repeat (9) cyc(1'b1, 1'b0, 1'b0);
    chk("t3_rem11", 32'(bus.remaining), 32'd11);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t3_yel", 32'(bus.lights), 32'(6'b000010));
    chk("t3_rem3", 32'(bus.remaining), 32'd3);

    // 4: no ticks for 1000 clk, requests toggling
    done_hi = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b0, 1'($urandom % 2), 1'($urandom % 2));
      if (bus.phase_done) done_hi++;
    end
    chk("t4_no_done", 32'(done_hi), 32'd0);

    // 5: reset pulse mid EW_GREEN
    advance_to(6'b001000);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    bus.tick = 0; bus.ns_req = 0; bus.ew_req = 0;
    #2 clr_n = 1'b0;
    #1;
    chk("t5_lights_async", 32'(bus.lights), 32'(6'b100000));
    chk("t5_red_async", 32'(bus.red_sel), 32'd1);
    chk("t5_rem", 32'(bus.remaining), 32'd2);
    chk("t5_pend_ns", 32'(dut.pend_ns), 32'd0);
    chk("t5_pend_ew", 32'(dut.pend_ew), 32'd0);
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
    check_outputs();
    cyc(1'b1, 1'b0, 1'b0);
    chk("t5_red_b_count", 32'(bus.remaining), 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
`ifdef TRAFFIC_PREEMPT_EN
      if ($urandom % 40 == 0) pre_v = !pre_v;
`endif
      cyc(1'($urandom % 3 == 0), 1'($urandom % 16 == 0), 1'($urandom % 16 == 0));
    end
    pre_v = 1'b0;

`ifdef TRAFFIC_PREEMPT_EN
    // 6: preempt in NS_GREEN, held through RED_A
    advance_to(6'b000001);
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    pre_v = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("t6_yel_now", 32'(bus.lights), 32'(6'b000010));
    advance_to(6'b000100);
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    chk("t6_red_hold", 32'(bus.lights), 32'(6'b000100));
    chk("t6_red_sat", 32'(bus.remaining), 32'd1);
    pre_v = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("t6_still_red", 32'(bus.lights), 32'(6'b000100));
    cyc(1'b1, 1'b0, 1'b0);
    chk("t6_ew_green", 32'(bus.lights), 32'(6'b001000));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
